// File: rtl/output_queue_bank.sv
// Per-source packet queues feeding output_module; only complete packets are advertised on empty_out.
// Read latency 1 cycle (port_out registered); writers are backpressured by wr_full, refused words set overflow.
// Optional DROP_ON_FULL_EN: a packet that hits a full queue is rewound to its last eop and discarded whole.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module output_queue_bank #(
   parameter int PORT_NUB   = `PORT_NUB_TOTAL,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int DEPTH      = 256,
   parameter int PKT_CNT_W  = 8
) (
   input  logic                             internal_clk,
   input  logic                             rst,
   input  logic [PORT_NUB-1:0]              wr_en,
   input  logic [PORT_NUB-1:0]              wr_eop,
   input  logic [PORT_NUB*DATA_WIDTH-1:0]   wr_data,
   output logic [PORT_NUB-1:0]              wr_full,
   output logic [PORT_NUB-1:0]              empty_out,
   input  logic [$clog2(PORT_NUB)-1:0]      rd_sel,
   input  logic                             rd_en,
   input  logic                             rd_done,
   output logic [DATA_WIDTH-1:0]            port_out,
   output logic [PORT_NUB-1:0]              overflow,
   output logic                             underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(PORT_NUB);
   localparam logic [PKT_CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_WIDTH-1:0]              mem [PORT_NUB][DEPTH];
   logic [PORT_NUB-1:0][AW:0]          wr_ptr;
   logic [PORT_NUB-1:0][AW:0]          rd_ptr;
   logic [PORT_NUB-1:0][PKT_CNT_W-1:0] pkt_cnt;

   logic [PORT_NUB-1:0] full;
   logic [PORT_NUB-1:0] word_empty;
   logic [PORT_NUB-1:0] wr_acc;
   logic [PORT_NUB-1:0] wr_refused;
   logic [PORT_NUB-1:0] eop_acc;
   logic [PORT_NUB-1:0] cnt_inc;
   logic [PORT_NUB-1:0] cnt_dec;
   logic [PORT_NUB-1:0] sat_ovf;
   logic                rd_hit;

`ifdef DROP_ON_FULL_EN
   logic [PORT_NUB-1:0][AW:0] commit_ptr;
   logic [PORT_NUB-1:0]       discard;
`endif

   always_comb begin
      full       = '0;
      word_empty = '0;
      wr_acc     = '0;
      wr_refused = '0;
      eop_acc    = '0;
      cnt_inc    = '0;
      cnt_dec    = '0;
      sat_ovf    = '0;
      for (int i = 0; i < PORT_NUB; i++) begin
         full[i]       = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) && (wr_ptr[i][AW] != rd_ptr[i][AW]);
         word_empty[i] = (wr_ptr[i] == rd_ptr[i]);
`ifdef DROP_ON_FULL_EN
         wr_acc[i]     = wr_en[i] & ~full[i] & ~discard[i];
         wr_refused[i] = wr_en[i] &  full[i] & ~discard[i];
`else
         wr_acc[i]     = wr_en[i] & ~full[i];
         wr_refused[i] = wr_en[i] &  full[i];
`endif
         eop_acc[i] = wr_acc[i] & wr_eop[i];
         cnt_dec[i] = rd_done && (rd_sel == SW'(i)) && (pkt_cnt[i] != '0);
         // A concurrent release frees a slot, so a saturated counter can still absorb the new packet
         cnt_inc[i] = eop_acc[i] && ((pkt_cnt[i] != CNT_MAX) || cnt_dec[i]);
         sat_ovf[i] = eop_acc[i] && (pkt_cnt[i] == CNT_MAX) && !cnt_dec[i];
      end
      rd_hit = rd_en & ~word_empty[rd_sel];
   end

   assign wr_full = full;

   always_comb begin
      empty_out = '0;
      for (int i = 0; i < PORT_NUB; i++) begin
         empty_out[i] = (pkt_cnt[i] == '0);
      end
   end

   // Storage carries no reset; a reset simply abandons its contents via the pointers
   always_ff @(posedge internal_clk) begin
      for (int i = 0; i < PORT_NUB; i++) begin
         if (wr_acc[i]) begin
            mem[i][wr_ptr[i][AW-1:0]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge internal_clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         overflow   <= '0;
         underflow  <= 1'b0;
         port_out   <= '0;
`ifdef DROP_ON_FULL_EN
         commit_ptr <= '0;
         discard    <= '0;
`endif
      end else begin
         for (int i = 0; i < PORT_NUB; i++) begin
            if (wr_acc[i]) begin
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            if (cnt_inc[i] && !cnt_dec[i]) begin
               pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
               pkt_cnt[i] <= pkt_cnt[i] - 1'b1;
            end
            if (wr_refused[i] || sat_ovf[i]) begin
               overflow[i] <= 1'b1;
            end
`ifdef DROP_ON_FULL_EN
            if (eop_acc[i]) begin
               commit_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            // Refusal drops the partial packet; the rest of it is swallowed up to its eop
            if (wr_refused[i]) begin
               wr_ptr[i]  <= commit_ptr[i];
               discard[i] <= ~wr_eop[i];
            end else if (discard[i] && wr_en[i] && wr_eop[i]) begin
               discard[i] <= 1'b0;
            end
`endif
         end

         if (rd_hit) begin
            port_out       <= mem[rd_sel][rd_ptr[rd_sel][AW-1:0]];
            rd_ptr[rd_sel] <= rd_ptr[rd_sel] + 1'b1;
         end else if (rd_en) begin
            underflow <= 1'b1;
         end
         if (rd_done && (pkt_cnt[rd_sel] == '0)) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_output_queue_bank.sv
// Directed bench for output_queue_bank: one task per scenario, inline checks.
module tb_output_queue_bank;

   localparam int P  = 16;
   localparam int DW = 32;

   logic              internal_clk = 1'b0;
   logic              rst;
   logic [P-1:0]      wr_en;
   logic [P-1:0]      wr_eop;
   logic [P*DW-1:0]   wr_data;
   logic [P-1:0]      wr_full;
   logic [P-1:0]      empty_out;
   logic [3:0]        rd_sel;
   logic              rd_en;
   logic              rd_done;
   logic [DW-1:0]     port_out;
   logic [P-1:0]      overflow;
   logic              underflow;

   int pass_cnt  = 0;
   int total_cnt = 0;

   output_queue_bank dut (
      .internal_clk (internal_clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_eop       (wr_eop),
      .wr_data      (wr_data),
      .wr_full      (wr_full),
      .empty_out    (empty_out),
      .rd_sel       (rd_sel),
      .rd_en        (rd_en),
      .rd_done      (rd_done),
      .port_out     (port_out),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 internal_clk = ~internal_clk;

   task automatic tick();
      @(posedge internal_clk);
      #1;
   endtask

   task automatic push(input int q, input logic [DW-1:0] d, input logic eop);
      wr_en = '0;
      wr_eop = '0;
      wr_en[q] = 1'b1;
      wr_eop[q] = eop;
      wr_data[q*DW +: DW] = d;
      tick();
      wr_en = '0;
      wr_eop = '0;
   endtask

   task automatic pop(input int q);
      rd_sel = 4'(q);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic release_pkt(input int q);
      rd_sel = 4'(q);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      push(3, 32'h11, 1'b0);
      push(3, 32'h22, 1'b1);
      total_cnt++; if (empty_out[3] !== 1'b0) $display("FAIL pre_reset_empty3: got %b expected 0", empty_out[3]); else pass_cnt++;
      pop(3);
      total_cnt++; if (port_out !== 32'h11) $display("FAIL pre_reset_port_out: got %h expected 00000011", port_out); else pass_cnt++;
      wr_en[3] = 1'b1;
      wr_data[3*DW +: DW] = 32'h33;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (empty_out !== 16'hFFFF) $display("FAIL reset_empty_out: got %h expected ffff", empty_out); else pass_cnt++;
      total_cnt++; if (port_out !== 32'h0) $display("FAIL reset_port_out: got %h expected 00000000", port_out); else pass_cnt++;
      total_cnt++; if (wr_full !== 16'h0) $display("FAIL reset_wr_full: got %h expected 0000", wr_full); else pass_cnt++;
      total_cnt++; if (overflow !== 16'h0 || underflow !== 1'b0) $display("FAIL reset_flags: got ovf=%h unf=%b expected 0000/0", overflow, underflow); else pass_cnt++;
      wr_en = '0;
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_packet();
      logic [DW-1:0] exp;
      for (int k = 0; k < 4; k++) push(2, 32'hA0 + 32'(k), 1'b0);
      total_cnt++; if (empty_out[2] !== 1'b1) $display("FAIL basic_before_eop: got %b expected 1", empty_out[2]); else pass_cnt++;
      push(2, 32'hA4, 1'b1);
      total_cnt++; if (empty_out[2] !== 1'b0) $display("FAIL basic_after_eop: got %b expected 0", empty_out[2]); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         pop(2);
         exp = 32'hA0 + 32'(k);
         total_cnt++; if (port_out !== exp) $display("FAIL basic_pop%0d: got %h expected %h", k, port_out, exp); else pass_cnt++;
      end
      tick();
      total_cnt++; if (port_out !== 32'hA4) $display("FAIL basic_hold: got %h expected 000000a4", port_out); else pass_cnt++;
      release_pkt(2);
      total_cnt++; if (empty_out[2] !== 1'b1) $display("FAIL basic_released: got %b expected 1", empty_out[2]); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL basic_no_underflow: got %b expected 0", underflow); else pass_cnt++;
   endtask

   task automatic test_partial();
      for (int k = 0; k < 4; k++) push(1, 32'hB0 + 32'(k), 1'b0);
      tick();
      tick();
      total_cnt++; if (empty_out[1] !== 1'b1) $display("FAIL partial_hidden: got %b expected 1", empty_out[1]); else pass_cnt++;
      push(1, 32'hB4, 1'b1);
      total_cnt++; if (empty_out[1] !== 1'b0) $display("FAIL partial_complete: got %b expected 0", empty_out[1]); else pass_cnt++;
      for (int k = 0; k < 5; k++) pop(1);
      total_cnt++; if (port_out !== 32'hB4) $display("FAIL partial_last_word: got %h expected 000000b4", port_out); else pass_cnt++;
      release_pkt(1);
      total_cnt++; if (empty_out !== 16'hFFFF) $display("FAIL partial_drained: got %h expected ffff", empty_out); else pass_cnt++;
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) push(0, 32'h100 + 32'(k), k == 3);
      for (int k = 0; k < 252; k++) push(0, 32'h200 + 32'(k), 1'b0);
      total_cnt++; if (wr_full[0] !== 1'b1) $display("FAIL full_asserted: got %b expected 1", wr_full[0]); else pass_cnt++;
      total_cnt++; if (overflow[0] !== 1'b0) $display("FAIL full_no_ovf_yet: got %b expected 0", overflow[0]); else pass_cnt++;
      push(0, 32'hDEAD, 1'b0);
      total_cnt++; if (overflow[0] !== 1'b1) $display("FAIL full_overflow: got %b expected 1", overflow[0]); else pass_cnt++;
      total_cnt++; if (empty_out[0] !== 1'b0) $display("FAIL full_pkt_kept: got %b expected 0", empty_out[0]); else pass_cnt++;
`ifdef DROP_ON_FULL_EN
      total_cnt++; if (wr_full[0] !== 1'b0) $display("FAIL full_rewound: got %b expected 0", wr_full[0]); else pass_cnt++;
      push(0, 32'hBEEF, 1'b1);
      release_pkt(0);
      total_cnt++; if (empty_out[0] !== 1'b1) $display("FAIL full_discarded_pkt: got %b expected 1", empty_out[0]); else pass_cnt++;
`else
      total_cnt++; if (wr_full[0] !== 1'b1) $display("FAIL full_still_full: got %b expected 1", wr_full[0]); else pass_cnt++;
`endif
      pop(0);
      total_cnt++; if (port_out !== 32'h100) $display("FAIL full_first_word: got %h expected 00000100", port_out); else pass_cnt++;
      total_cnt++; if (wr_full[0] !== 1'b0) $display("FAIL full_after_pop: got %b expected 0", wr_full[0]); else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      push(5, 32'h51, 1'b0);
      push(5, 32'h52, 1'b1);
      wr_en[5] = 1'b1;
      wr_eop[5] = 1'b1;
      wr_data[5*DW +: DW] = 32'h53;
      rd_sel = 4'd5;
      rd_done = 1'b1;
      tick();
      wr_en = '0;
      wr_eop = '0;
      rd_done = 1'b0;
      total_cnt++; if (empty_out[5] !== 1'b0) $display("FAIL same_cycle_cnt_kept: got %b expected 0", empty_out[5]); else pass_cnt++;
      release_pkt(5);
      total_cnt++; if (empty_out[5] !== 1'b1) $display("FAIL same_cycle_cnt_was_one: got %b expected 1", empty_out[5]); else pass_cnt++;
      wr_en[5] = 1'b1;
      wr_data[5*DW +: DW] = 32'h54;
      pop(5);
      wr_en = '0;
      total_cnt++; if (port_out !== 32'h51) $display("FAIL same_cycle_rd_wr: got %h expected 00000051", port_out); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL same_cycle_no_underflow: got %b expected 0", underflow); else pass_cnt++;
   endtask

   task automatic test_underflow();
      pop(7);
      total_cnt++; if (underflow !== 1'b1) $display("FAIL underflow_rd_en: got %b expected 1", underflow); else pass_cnt++;
      total_cnt++; if (port_out !== 32'h51) $display("FAIL underflow_port_hold: got %h expected 00000051", port_out); else pass_cnt++;
      push(7, 32'h71, 1'b1);
      pop(7);
      total_cnt++; if (port_out !== 32'h71) $display("FAIL underflow_ptr_kept: got %h expected 00000071", port_out); else pass_cnt++;
      release_pkt(7);
      total_cnt++; if (empty_out[7] !== 1'b1 || underflow !== 1'b1) $display("FAIL underflow_sticky: got empty=%b unf=%b expected 1/1", empty_out[7], underflow); else pass_cnt++;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      total_cnt++; if (underflow !== 1'b0) $display("FAIL underflow_cleared: got %b expected 0", underflow); else pass_cnt++;
      release_pkt(7);
      total_cnt++; if (underflow !== 1'b1) $display("FAIL underflow_rd_done: got %b expected 1", underflow); else pass_cnt++;
      total_cnt++; if (empty_out !== 16'hFFFF) $display("FAIL underflow_cnt_unchanged: got %h expected ffff", empty_out); else pass_cnt++;
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = '0;
      wr_eop  = '0;
      wr_data = '0;
      rd_sel  = '0;
      rd_en   = 1'b0;
      rd_done = 1'b0;
      test_reset();
      test_basic_packet();
      test_partial();
      test_full();
      test_same_cycle();
      test_underflow();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
